// File: rtl/lime_io_pkg.sv
// Shared constants and types for the Lime host-side I/O port.
package lime_io_pkg;

  localparam int WORD_W          = 16;
  localparam int IN_DEPTH_DEF    = 4;
  localparam int OUT_DEPTH_DEF   = 8;
  localparam int HOLD_CYCLES_DEF = 4;
  localparam int TS_W_DEF        = 16;

  // Ingress presenter: either waiting for a word or holding one on main_input.
  typedef enum logic [0:0] {
    PRES_IDLE = 1'b0,
    PRES_HOLD = 1'b1
  } pres_state_e;

  // Egress entry at the default timestamp width; stamp sits in the upper bits.
  typedef struct packed {
    logic [TS_W_DEF-1:0] stamp;
    logic [WORD_W-1:0]   data;
  } egr_entry_t;

endpackage

// File: rtl/lime_sync_fifo.sv
// Show-ahead synchronous FIFO. A push while full is taken only when a pop
// frees the head slot at the same edge; a pop while empty is ignored.
module lime_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage values for this edge's push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless while empty, so it is not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lime_io_port.sv
// Host-side I/O partner of the Lime core: paces host words onto main_input
// and logs every change of main_output with a cycle timestamp.
module lime_io_port
  import lime_io_pkg::*;
#(
  parameter int IN_DEPTH    = IN_DEPTH_DEF,
  parameter int OUT_DEPTH   = OUT_DEPTH_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int TS_W        = TS_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [WORD_W-1:0] main_output,
  output logic [WORD_W-1:0] main_input,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  input  logic [WORD_W-1:0] host_in_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic [WORD_W-1:0] host_out_data,
  output logic [TS_W-1:0]   host_out_stamp,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  // Same layout as egr_entry_t, but sized by this instance's TS_W.
  typedef struct packed {
    logic [TS_W-1:0]   stamp;
    logic [WORD_W-1:0] data;
  } egr_slot_t;

  // Ingress FIFO and presenter
  logic              in_push;
  logic              in_pop;
  logic              in_full;
  logic              in_empty;
  logic [WORD_W-1:0] in_head;

  pres_state_e       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] main_input_q, main_input_d;

  // Egress path
  logic [TS_W-1:0]   stamp_q, stamp_d;
  logic [WORD_W-1:0] prev_out_q, prev_out_d;
  logic              overflow_q, overflow_d;
  logic              change;
  logic              out_pop;
  logic              out_full;
  logic              out_empty;
  logic              drop;
  egr_slot_t         out_entry;
  egr_slot_t         out_head;

  assign host_in_ready = ~in_full;
  assign in_push       = host_in_valid & ~in_full;

  lime_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (in_push),
    .din   (host_in_data),
    .pop   (in_pop),
    .full  (in_full),
    .empty (in_empty),
    .head  (in_head)
  );

  // Presenter: take a word when idle, then keep it up for HOLD_CYCLES edges.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    main_input_d = main_input_q;
    in_pop       = 1'b0;
    case (state_q)
      PRES_IDLE: begin
        if (!in_empty) begin
          in_pop       = 1'b1;
          main_input_d = in_head;
          count_d      = HOLD_LOAD;
          state_d      = (HOLD_CYCLES == 1) ? PRES_IDLE : PRES_HOLD;
        end else begin
          state_d = PRES_IDLE;
        end
      end
      PRES_HOLD: begin
        // Leaving on the edge that brings the count to zero makes the word's
        // total time on main_input exactly HOLD_CYCLES.
        if (count_q <= CNT_W'(1)) begin
          count_d = '0;
          state_d = PRES_IDLE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        count_d = '0;
        state_d = PRES_IDLE;
      end
    endcase
  end

  // Change detector, free-running stamp and sticky overflow (set beats clear).
  always_comb begin
    stamp_d    = stamp_q + TS_W'(1);
    prev_out_d = main_output;
    change     = (main_output != prev_out_q);
    out_pop    = ~out_empty & host_out_ready;
    drop       = change & out_full & ~out_pop;
    out_entry  = '{stamp: stamp_q, data: main_output};
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  lime_sync_fifo #(
    .WIDTH ($bits(egr_slot_t)),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (change),
    .din   (out_entry),
    .pop   (out_pop),
    .full  (out_full),
    .empty (out_empty),
    .head  (out_head)
  );

  // Top-level state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= PRES_IDLE;
      count_q      <= '0;
      main_input_q <= '0;
      stamp_q      <= '0;
      prev_out_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      main_input_q <= main_input_d;
      stamp_q      <= stamp_d;
      prev_out_q   <= prev_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign main_input     = main_input_q;
  assign host_out_valid = ~out_empty;
  assign host_out_data  = out_head.data;
  assign host_out_stamp = out_head.stamp;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_lime_io_port.sv
// Directed bench for lime_io_port: a vector table for ingress pacing and
// basic egress capture, plus hand sequences for overflow, mid-run reset
// and timestamp wrap on a narrow-stamp instance.
module tb_lime_io_port;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Default instance
  logic        Reset = 1'b1;
  logic [15:0] main_output = 16'h0000;
  logic [15:0] main_input;
  logic        host_in_valid = 1'b0;
  logic        host_in_ready;
  logic [15:0] host_in_data = 16'h0000;
  logic        host_out_valid;
  logic        host_out_ready = 1'b0;
  logic [15:0] host_out_data;
  logic [15:0] host_out_stamp;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  // Narrow-stamp instance (TS_W=4)
  logic        w_reset = 1'b1;
  logic [15:0] w_mo = 16'h0000;
  logic [15:0] w_mi;
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [15:0] w_in_data = 16'h0000;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [15:0] w_out_data;
  logic [3:0]  w_out_stamp;
  logic        w_overflow;
  logic        w_clear = 1'b0;

  lime_io_port u_dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .main_output    (main_output),
    .main_input     (main_input),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_in_data   (host_in_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_out_data  (host_out_data),
    .host_out_stamp (host_out_stamp),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  lime_io_port #(.TS_W(4)) u_w (
    .CLK            (CLK),
    .Reset          (w_reset),
    .main_output    (w_mo),
    .main_input     (w_mi),
    .host_in_valid  (w_in_valid),
    .host_in_ready  (w_in_ready),
    .host_in_data   (w_in_data),
    .host_out_valid (w_out_valid),
    .host_out_ready (w_out_ready),
    .host_out_data  (w_out_data),
    .host_out_stamp (w_out_stamp),
    .overflow       (w_overflow),
    .clear_overflow (w_clear)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] id;
    logic [15:0] mo;
    logic        ordy;
    logic        clr;
    logic [15:0] e_mi;
    logic        e_rdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic [15:0] e_st;
    logic        e_ovf;
  } vec_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] d;
  } wexp_t;

  vec_t  tbl[$];
  wexp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic rst, input logic iv, input logic [15:0] id,
                     input logic [15:0] mo, input logic ordy, input logic clr,
                     input logic [15:0] e_mi, input logic e_rdy, input logic e_ov,
                     input logic [15:0] e_od, input logic [15:0] e_st, input logic e_ovf);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.mo = mo; v.ordy = ordy; v.clr = clr;
    v.e_mi = e_mi; v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_st = e_st; v.e_ovf = e_ovf;
    tbl.push_back(v);
  endtask

  initial begin
    // ---------------- vector table (edge i = table row i) ----------------
    add(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 1; i <= 4; i++)
      add(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    add(1'b0, 1'b1, 16'h1234, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 6; i <= 9; i++)
      add(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 10; i <= 12; i++)
      add(1'b0, 1'b0, 16'h0, 16'h0001, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 16'h0001, 16'd9, 1'b0);
    for (int i = 13; i <= 14; i++)
      add(1'b0, 1'b0, 16'h0, 16'h0002, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 16'h0001, 16'd9, 1'b0);
    add(1'b0, 1'b0, 16'h0, 16'h0002, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 16'h0002, 16'd12, 1'b0);
    add(1'b0, 1'b0, 16'h0, 16'h0002, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    add(1'b0, 1'b0, 16'h0, 16'h0002, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    add(1'b0, 1'b1, 16'h5555, 16'h0002, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    add(1'b0, 1'b1, 16'hAAAA, 16'h0002, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    add(1'b0, 1'b1, 16'hBBBB, 16'h0002, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    add(1'b0, 1'b1, 16'hCCCC, 16'h0002, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    add(1'b0, 1'b1, 16'hDDDD, 16'h0002, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 23; i <= 26; i++)
      add(1'b0, 1'b0, 16'h0, 16'h0002, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 27; i <= 30; i++)
      add(1'b0, 1'b0, 16'h0, 16'h0002, 1'b0, 1'b0, 16'hBBBB, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 31; i <= 34; i++)
      add(1'b0, 1'b0, 16'h0, 16'h0002, 1'b0, 1'b0, 16'hCCCC, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 35; i <= 40; i++)
      add(1'b0, 1'b0, 16'h0, 16'h0002, 1'b0, 1'b0, 16'hDDDD, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);

    foreach (tbl[i]) begin
      Reset          = tbl[i].rst;
      host_in_valid  = tbl[i].iv;
      host_in_data   = tbl[i].id;
      main_output    = tbl[i].mo;
      host_out_ready = tbl[i].ordy;
      clear_overflow = tbl[i].clr;
      tick();
      check($sformatf("v%0d main_input", i), 32'(main_input), 32'(tbl[i].e_mi));
      check($sformatf("v%0d in_ready", i), 32'(host_in_ready), 32'(tbl[i].e_rdy));
      check($sformatf("v%0d out_valid", i), 32'(host_out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        check($sformatf("v%0d out_data", i), 32'(host_out_data), 32'(tbl[i].e_od));
        check($sformatf("v%0d out_stamp", i), 32'(host_out_stamp), 32'(tbl[i].e_st));
      end
      check($sformatf("v%0d overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
    end
    host_in_valid  = 1'b0;
    host_out_ready = 1'b0;

    // ---------------- overflow: 9 changes into 8 slots ----------------
    Reset = 1'b1; main_output = 16'h0; tick(); Reset = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      main_output = 16'(e);
      tick();
      if (e == 8) begin
        check("ovf full valid", 32'(host_out_valid), 32'd1);
        check("ovf before drop", 32'(overflow), 32'd0);
      end
      if (e == 9) check("ovf after drop", 32'(overflow), 32'd1);
    end
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    check("ovf cleared", 32'(overflow), 32'd0);
    main_output = 16'd10; host_out_ready = 1'b1; tick();
    check("ovf full push+pop", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d valid", k), 32'(host_out_valid), 32'd1);
      check($sformatf("drain%0d data", k), 32'(host_out_data), (k < 7) ? 32'(k + 2) : 32'd10);
      check($sformatf("drain%0d stamp", k), 32'(host_out_stamp), (k < 7) ? 32'(k + 1) : 32'd10);
      tick();
    end
    check("drain empty", 32'(host_out_valid), 32'd0);
    host_out_ready = 1'b0;

    // ---------------- reset mid-HOLD with both FIFOs non-empty ----------------
    Reset = 1'b1; main_output = 16'h0; tick(); Reset = 1'b0;
    host_in_valid = 1'b1; host_in_data = 16'h1111; tick();
    host_in_data = 16'h2222; main_output = 16'h0007; tick();
    host_in_valid = 1'b0; tick();
    check("pre-reset main_input", 32'(main_input), 32'h1111);
    check("pre-reset out_valid", 32'(host_out_valid), 32'd1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("rst main_input", 32'(main_input), 32'd0);
    check("rst in_ready", 32'(host_in_ready), 32'd1);
    check("rst out_valid", 32'(host_out_valid), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    tick();
    check("post-rst event valid", 32'(host_out_valid), 32'd1);
    check("post-rst event data", 32'(host_out_data), 32'h0007);
    check("post-rst stamp restart", 32'(host_out_stamp), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("pending never shown %0d", k), 32'(main_input), 32'd0);
    end

    // ---------------- TS_W=4 wrap with random drain ----------------
    w_reset = 1'b1; tick(); w_reset = 1'b0;
    for (int n = 1; n <= 55; n++) begin
      logic rdy;
      check($sformatf("w%0d valid", n), 32'(w_out_valid), 32'(exp_q.size() != 0));
      rdy = (n > 45) ? 1'b1 : 1'($urandom_range(0, 1));
      w_out_ready = rdy;
      if (w_out_valid && rdy && exp_q.size() != 0) begin
        check($sformatf("w%0d data", n), 32'(w_out_data), 32'(exp_q[0].d));
        check($sformatf("w%0d stamp", n), 32'(w_out_stamp), 32'(exp_q[0].st));
        void'(exp_q.pop_front());
      end
      if ((n % 5 == 0) && (n <= 40)) begin
        wexp_t x;
        w_mo = 16'(n / 5);
        x.st = 4'((n - 1) % 16);
        x.d  = 16'(n / 5);
        exp_q.push_back(x);
      end
      tick();
    end
    check("w all drained", 32'(exp_q.size()), 32'd0);
    check("w final valid", 32'(w_out_valid), 32'd0);
    check("w overflow", 32'(w_overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
